// File: rtl/ram_pkg.sv
// Shared definitions for the two-port buffered RAM: address-width macro,
// FSM state encoding and the byte-merge helper used by write forwarding.
`ifndef RAM_LOG2
`define RAM_LOG2(n) $clog2(n)
`endif

package ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ram_state_e;

  // Selects the new byte where its enable is set, otherwise keeps the old one.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       be);
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/fifo_2entry.sv
// Two-entry output FIFO with valid/retry handshake on both sides.
// The input-side retry is a pure function of occupancy, so it never loops back to the inputs.
module fifo_2entry #(
  parameter int Width = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_retry,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_retry,
  output logic [Width-1:0] out_data
);

  logic [1:0]       cnt_q, cnt_d;
  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  logic             push;
  logic             pop;

  assign in_retry  = (cnt_q == 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid && !in_retry;
  assign pop       = out_valid && !out_retry;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = in_data;
        else               tail_d = in_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      // Push alongside pop only happens with one entry held: the new data becomes the head.
      2'b11: head_d = in_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      // NOTE: state flops use non-blocking assignment so all of them see pre-edge values.
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/ram_2port_buf.sv
// Simple dual-port RAM with byte enables, zero-clear after reset, optional
// same-cycle write forwarding and a 2-entry registered read-response buffer.
`ifndef RAM_LOG2
`define RAM_LOG2(n) $clog2(n)
`endif

module ram_2port_buf
  import ram_pkg::*;
#(
  parameter int Width   = 64,
  parameter int Size    = 128,
  parameter int Forward = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_wr_valid,
  output logic                        req_wr_retry,
  input  logic [`RAM_LOG2(Size)-1:0]  req_wr_addr,
  input  logic [Width-1:0]            req_wr_data,
  input  logic [Width/8-1:0]          req_wr_be,
  input  logic                        req_rd_valid,
  output logic                        req_rd_retry,
  input  logic [`RAM_LOG2(Size)-1:0]  req_rd_addr,
  output logic                        ack_rd_valid,
  input  logic                        ack_rd_retry,
  output logic [Width-1:0]            ack_rd_data,
  output logic                        init_done
);

  localparam int AW = `RAM_LOG2(Size);
  localparam int BW = Width / 8;

  ram_state_e       state_q, state_d;
  logic [AW-1:0]    init_cnt_q, init_cnt_d;
  logic             init_done_q, init_done_d;
  logic             wr_retry_q, wr_retry_d;

  logic [Width-1:0] mem [Size];

  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_en;
  logic             rd_accept;
  logic             fwd_hit;
  logic             fifo_full;
  logic [Width-1:0] rd_data;

  assign wr_in_range = int'(req_wr_addr) < Size;
  assign rd_in_range = int'(req_rd_addr) < Size;
  assign wr_en       = (state_q == ST_RUN) && req_wr_valid && wr_in_range;

  // Read retry comes only from registered state, never from the request or ack inputs.
  assign req_rd_retry = (state_q == ST_INIT) || fifo_full;
  assign req_wr_retry = wr_retry_q;
  assign init_done    = init_done_q;
  assign rd_accept    = req_rd_valid && !req_rd_retry;
  assign fwd_hit      = (Forward != 0) && wr_en && (req_wr_addr == req_rd_addr);

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    wr_retry_d  = wr_retry_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == AW'(Size - 1)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
          wr_retry_d  = 1'b0;
        end else begin
          init_cnt_d = init_cnt_q + AW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      wr_retry_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      wr_retry_q  <= wr_retry_d;
    end
  end

  // NOTE: the array is deliberately left out of reset so it maps onto RAM; INIT zeroes it instead.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[init_cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < BW; i++) begin
        if (req_wr_be[i]) mem[req_wr_addr][8*i +: 8] <= req_wr_data[8*i +: 8];
      end
    end
  end

  // Out-of-range reads return zero; a same-address write overlays its enabled bytes when forwarding.
  always_comb begin
    rd_data = '0;
    if (rd_in_range) rd_data = mem[req_rd_addr];
    if (fwd_hit) begin
      for (int i = 0; i < BW; i++) begin
        rd_data[8*i +: 8] = byte_merge(rd_data[8*i +: 8], req_wr_data[8*i +: 8], req_wr_be[i]);
      end
    end
  end

  fifo_2entry #(
    .Width(Width)
  ) u_out_fifo (
    .clk      (clk),
    .reset    (reset),
    .in_valid (rd_accept),
    .in_retry (fifo_full),
    .in_data  (rd_data),
    .out_valid(ack_rd_valid),
    .out_retry(ack_rd_retry),
    .out_data (ack_rd_data)
  );

endmodule

// File: tb/tb_ram_2port_buf.sv
// Bench for ram_2port_buf: a forwarding 16-entry instance and a non-forwarding
// 12-entry instance share stimulus and are scored against an array/queue model.
module tb_ram_2port_buf;

  localparam int W  = 64;
  localparam int SA = 16;
  localparam int SB = 12;
  localparam int AW = 4;
  localparam int BW = W / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [BW-1:0] wr_be = '0;
  logic          rd_valid = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          ack_retry = 1'b0;

  logic          a_wr_retry, a_rd_retry, a_ack_valid, a_init_done;
  logic [W-1:0]  a_ack_data;
  logic          b_wr_retry, b_rd_retry, b_ack_valid, b_init_done;
  logic [W-1:0]  b_ack_data;

  always #5 clk = ~clk;

  ram_2port_buf #(.Width(W), .Size(SA), .Forward(1)) dut_a (
    .clk(clk), .reset(reset),
    .req_wr_valid(wr_valid), .req_wr_retry(a_wr_retry), .req_wr_addr(wr_addr),
    .req_wr_data(wr_data), .req_wr_be(wr_be),
    .req_rd_valid(rd_valid), .req_rd_retry(a_rd_retry), .req_rd_addr(rd_addr),
    .ack_rd_valid(a_ack_valid), .ack_rd_retry(ack_retry), .ack_rd_data(a_ack_data),
    .init_done(a_init_done)
  );

  ram_2port_buf #(.Width(W), .Size(SB), .Forward(0)) dut_b (
    .clk(clk), .reset(reset),
    .req_wr_valid(wr_valid), .req_wr_retry(b_wr_retry), .req_wr_addr(wr_addr),
    .req_wr_data(wr_data), .req_wr_be(wr_be),
    .req_rd_valid(rd_valid), .req_rd_retry(b_rd_retry), .req_rd_addr(rd_addr),
    .ack_rd_valid(b_ack_valid), .ack_rd_retry(ack_retry), .ack_rd_data(b_ack_data),
    .init_done(b_init_done)
  );

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] mem_a [SA];
  logic [W-1:0] mem_b [SB];
  logic [W-1:0] qa [$];
  logic [W-1:0] qb [$];
  bit           running = 1'b0;
  bit           last_accept = 1'b0;

  function automatic logic [W-1:0] apply_be(input logic [W-1:0] old_v,
                                            input logic [W-1:0] new_v,
                                            input logic [BW-1:0] be);
    logic [W-1:0] r = old_v;
    for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    wr_be    = '0;
  endtask

  task automatic clear_models();
    for (int i = 0; i < SA; i++) mem_a[i] = '0;
    for (int i = 0; i < SB; i++) mem_b[i] = '0;
  endtask

  // One clock of the reference model: score the pre-edge outputs, then advance the model and the clock.
  task automatic tick();
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
    bit           acc;
    checks++;
    if (a_ack_valid !== (qa.size() > 0)) begin
      errors++;
      $display("FAIL ack_valid_a got %b exp %b", a_ack_valid, qa.size() > 0);
    end
    checks++;
    if (b_ack_valid !== (qb.size() > 0)) begin
      errors++;
      $display("FAIL ack_valid_b got %b exp %b", b_ack_valid, qb.size() > 0);
    end
    if (running) begin
      checks++;
      if (a_rd_retry !== (qa.size() >= 2) || b_rd_retry !== (qb.size() >= 2)) begin
        errors++;
        $display("FAIL rd_retry got a=%b b=%b exp %b", a_rd_retry, b_rd_retry, qa.size() >= 2);
      end
      checks++;
      if (a_wr_retry !== 1'b0 || b_wr_retry !== 1'b0) begin
        errors++;
        $display("FAIL wr_retry_run got a=%b b=%b exp 0", a_wr_retry, b_wr_retry);
      end
    end
    acc = running && rd_valid && (qa.size() < 2);
    if (!ack_retry && qa.size() > 0) begin
      exp_a = qa.pop_front();
      checks++;
      if (a_ack_data !== exp_a) begin
        errors++;
        $display("FAIL ack_data_a got %h exp %h", a_ack_data, exp_a);
      end
    end
    if (!ack_retry && qb.size() > 0) begin
      exp_b = qb.pop_front();
      checks++;
      if (b_ack_data !== exp_b) begin
        errors++;
        $display("FAIL ack_data_b got %h exp %h", b_ack_data, exp_b);
      end
    end
    if (acc) begin
      exp_a = (int'(rd_addr) < SA) ? mem_a[rd_addr] : '0;
      if (wr_valid && wr_addr == rd_addr && int'(rd_addr) < SA) exp_a = apply_be(exp_a, wr_data, wr_be);
      qa.push_back(exp_a);
      exp_b = (int'(rd_addr) < SB) ? mem_b[rd_addr] : '0;
      qb.push_back(exp_b);
    end
    if (running && wr_valid) begin
      if (int'(wr_addr) < SA) mem_a[wr_addr] = apply_be(mem_a[wr_addr], wr_data, wr_be);
      if (int'(wr_addr) < SB) mem_b[wr_addr] = apply_be(mem_b[wr_addr], wr_data, wr_be);
    end
    last_accept = acc;
    @(posedge clk);
    #1;
  endtask

  // Called just after reset release; counts edges until each instance reports init_done.
  task automatic wait_init(output int a_at, output int b_at);
    a_at = -1;
    b_at = -1;
    for (int n = 1; n <= 40 && a_at < 0; n++) begin
      if (!a_init_done) begin
        checks++;
        if (a_wr_retry !== 1'b1 || a_rd_retry !== 1'b1) begin
          errors++;
          $display("FAIL init_retry_a cycle %0d got wr=%b rd=%b exp 1", n, a_wr_retry, a_rd_retry);
        end
      end
      tick();
      if (a_init_done === 1'b1 && a_at < 0) a_at = n;
      if (b_init_done === 1'b1 && b_at < 0) b_at = n;
    end
    clear_models();
    running = 1'b1;
  endtask

  task automatic test_reset();
    int a_at, b_at;
    idle_inputs();
    running = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_ack_valid !== 1'b0 || b_ack_valid !== 1'b0 || a_init_done !== 1'b0 || b_init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_done got %b%b%b%b exp 0000", a_ack_valid, b_ack_valid, a_init_done, b_init_done);
    end
    checks++;
    if (a_wr_retry !== 1'b1 || a_rd_retry !== 1'b1 || b_wr_retry !== 1'b1 || b_rd_retry !== 1'b1) begin
      errors++;
      $display("FAIL reset_retry got %b%b%b%b exp 1111", a_wr_retry, a_rd_retry, b_wr_retry, b_rd_retry);
    end
    checks++;
    if (a_ack_data !== '0 || b_ack_data !== '0) begin
      errors++;
      $display("FAIL reset_data got %h %h exp 0", a_ack_data, b_ack_data);
    end
    reset = 1'b1;
    wait_init(a_at, b_at);
    checks++;
    if (a_at != SA) begin
      errors++;
      $display("FAIL init_len_a got %0d exp %0d", a_at, SA);
    end
    checks++;
    if (b_at != SB) begin
      errors++;
      $display("FAIL init_len_b got %0d exp %0d", b_at, SB);
    end
  endtask

  task automatic test_write_read();
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 64'h1122334455667788; wr_be = 8'hFF;
    tick();
    wr_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 4'd3;
    tick();
    rd_valid = 1'b0;
    checks++;
    if (a_ack_valid !== 1'b1 || a_ack_data !== 64'h1122334455667788) begin
      errors++;
      $display("FAIL write_read got v=%b d=%h exp v=1 d=1122334455667788", a_ack_valid, a_ack_data);
    end
    tick();
  endtask

  task automatic test_forward();
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = '1; wr_be = 8'h0F;
    rd_valid = 1'b1; rd_addr = 4'd5;
    tick();
    idle_inputs();
    checks++;
    if (a_ack_data !== 64'h00000000FFFFFFFF) begin
      errors++;
      $display("FAIL forward_on got %h exp 00000000ffffffff", a_ack_data);
    end
    checks++;
    if (b_ack_data !== 64'h0) begin
      errors++;
      $display("FAIL forward_off got %h exp 0", b_ack_data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    int           k;
    ack_retry = 1'b1;
    rd_valid = 1'b1;
    rd_addr = 4'd3;
    tick();
    rd_addr = 4'd5;
    tick();
    rd_addr = 4'd0;
    checks++;
    if (a_rd_retry !== 1'b1) begin
      errors++;
      $display("FAIL third_read_refused got %b exp 1", a_rd_retry);
    end
    held = a_ack_data;
    tick();
    tick();
    checks++;
    if (a_ack_valid !== 1'b1 || a_ack_data !== held) begin
      errors++;
      $display("FAIL stall_stable got v=%b d=%h exp v=1 d=%h", a_ack_valid, a_ack_data, held);
    end
    ack_retry = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (!last_accept && k < 6);
    checks++;
    if (k != 2) begin
      errors++;
      $display("FAIL third_read_accept got %0d cycles exp 2", k);
    end
    rd_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    int ones, streak, max_streak;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(i); wr_data = {$urandom, $urandom}; wr_be = '1;
      tick();
    end
    wr_valid = 1'b0;
    ones = 0; streak = 0; max_streak = 0;
    for (int i = 0; i < 11; i++) begin
      rd_valid = (i < 8);
      rd_addr  = AW'(i);
      tick();
      if (a_ack_valid === 1'b1) begin
        ones++;
        streak++;
        if (streak > max_streak) max_streak = streak;
      end else begin
        streak = 0;
      end
    end
    rd_valid = 1'b0;
    checks++;
    if (ones != 8 || max_streak != 8) begin
      errors++;
      $display("FAIL back_to_back got ones=%0d streak=%0d exp 8/8", ones, max_streak);
    end
  endtask

  task automatic test_out_of_range();
    logic [W-1:0] d;
    d = {$urandom, $urandom} | 64'h1;
    wr_valid = 1'b1; wr_addr = 4'd14; wr_data = d; wr_be = '1;
    tick();
    wr_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 4'd14;
    tick();
    rd_valid = 1'b0;
    checks++;
    if (b_ack_valid !== 1'b1 || b_ack_data !== '0) begin
      errors++;
      $display("FAIL out_of_range_b got v=%b d=%h exp v=1 d=0", b_ack_valid, b_ack_data);
    end
    checks++;
    if (a_ack_data !== d) begin
      errors++;
      $display("FAIL in_range_a got %h exp %h", a_ack_data, d);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wr_valid  = 1'($urandom_range(0, 1));
      wr_addr   = AW'($urandom_range(0, 15));
      wr_data   = {$urandom, $urandom};
      wr_be     = BW'($urandom);
      rd_valid  = 1'($urandom_range(0, 1));
      rd_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 15));
      ack_retry = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle_inputs();
    ack_retry = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    int a_at, b_at;
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 64'hDEADBEEF0BADF00D; wr_be = '1;
    tick();
    wr_valid = 1'b0;
    ack_retry = 1'b1;
    rd_valid = 1'b1; rd_addr = 4'd3;
    repeat (2) tick();
    rd_valid = 1'b0;
    checks++;
    if (a_ack_valid !== 1'b1 || a_rd_retry !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_full got v=%b retry=%b exp 1/1", a_ack_valid, a_rd_retry);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (a_ack_valid !== 1'b0 || b_ack_valid !== 1'b0 || a_ack_data !== '0 || a_init_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got v=%b%b d=%h done=%b exp 00/0/0", a_ack_valid, b_ack_valid, a_ack_data, a_init_done);
    end
    running = 1'b0;
    qa.delete();
    qb.delete();
    ack_retry = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_init(a_at, b_at);
    checks++;
    if (a_at != SA) begin
      errors++;
      $display("FAIL reinit_len_a got %0d exp %0d", a_at, SA);
    end
    rd_valid = 1'b1; rd_addr = 4'd3;
    tick();
    rd_valid = 1'b0;
    checks++;
    if (a_ack_valid !== 1'b1 || a_ack_data !== '0) begin
      errors++;
      $display("FAIL reinit_cleared got v=%b d=%h exp v=1 d=0", a_ack_valid, a_ack_data);
    end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_forward();
    test_backpressure();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

endmodule

// File: doc/ram_2port_buf.md
RAM_2PORT_BUF -- requirements
Module: ram_2port_buf

Interface
REQ-001 Parameter Width, default 64: data bits per entry; SHALL be a multiple of 8, range 8..512.
REQ-002 Parameter Size, default 128: number of entries, range 8..1024; need not be a power of 2.
REQ-003 Parameter Forward, default 1: 1 = same-cycle write-to-read bypass, 0 = read returns pre-write data.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_wr_valid  input  1  write request.
REQ-007 req_wr_retry  output  1  write not accepted this cycle.
REQ-008 req_wr_addr  input  log2(Size)  write address.
REQ-009 req_wr_data  input  Width  write data.
REQ-010 req_wr_be  input  Width/8  byte enables; bit i covers data[8i+7:8i].
REQ-011 req_rd_valid  input  1  read request.
REQ-012 req_rd_retry  output  1  read not accepted this cycle.
REQ-013 req_rd_addr  input  log2(Size)  read address.
REQ-014 ack_rd_valid  output  1  read data available.
REQ-015 ack_rd_retry  input  1  consumer stall.
REQ-016 ack_rd_data  output  Width  read data.
REQ-017 init_done  output  1  high once memory clear completes.

Function
REQ-018 The block SHALL have a two-state FSM: INIT and RUN.
- INIT: counter walks 0..Size-1, writing zero to one entry per cycle; req_wr_retry = req_rd_retry = 1; init_done = 0.
- INIT -> RUN on the cycle that clears entry Size-1; INIT SHALL last exactly Size cycles after reset release.
REQ-019 In RUN, req_wr_retry SHALL be 0; a write with req_wr_valid = 1 SHALL update only the bytes whose req_wr_be bit is 1.
REQ-020 In RUN, a read SHALL be accepted when req_rd_valid = 1 and req_rd_retry = 0.
REQ-021 Output stage: 2-entry FIFO; each accepted read SHALL push array data at the next edge, giving 1-cycle latency (ack_rd_valid high in the cycle after acceptance).
REQ-022 req_rd_retry SHALL be 1 iff state is INIT or the FIFO holds 2 entries; it SHALL NOT depend combinationally on ack_rd_retry or any request input.
REQ-023 The FIFO SHALL pop when ack_rd_valid = 1 and ack_rd_retry = 0.
- ack_rd_data SHALL stay stable while ack_rd_valid = 1 and ack_rd_retry = 1.
- Responses SHALL return in request order.
REQ-024 Push and pop in the same cycle SHALL leave the occupancy count unchanged; full throughput (one read per cycle) SHALL be sustained while ack_rd_retry = 0.
REQ-025 Read and write to the same address in the same cycle: with Forward = 1, the read SHALL return new bytes where be = 1 and old bytes elsewhere; with Forward = 0, it SHALL return old data.
REQ-026 Addresses >= Size: writes SHALL be dropped and reads SHALL return all-zero data, with normal handshake.
REQ-027 Simultaneous valid read and write to different addresses SHALL both complete in one cycle.

Reset
REQ-028 While reset = 0: state = INIT, init counter = 0, FIFO empty, ack_rd_valid = 0, init_done = 0, req_wr_retry = 1, req_rd_retry = 1, ack_rd_data = 0.
REQ-029 Reset asserted mid-operation SHALL discard buffered responses and in-flight reads, and SHALL restart the full INIT clear on release.
REQ-030 The storage array itself SHALL NOT be reset; INIT provides the clearing.

Structure
REQ-031 Address width SHALL come from the shared log2 macro; the FSM state enum and a byte-merge helper function SHALL reside in a shared package, ram_pkg.
REQ-032 The 2-entry output FIFO SHALL be a sub-module, fifo_2entry, parametrised by Width, with valid/retry on both sides.

Verification
REQ-033 Release reset with Size = 16 -> init_done rises exactly 16 cycles later; both retries are 1 throughout INIT.
REQ-034 Write addr 3 = 0x1122334455667788 with be = 0xFF, then read addr 3 -> ack_rd_valid one cycle after acceptance, data 0x1122334455667788.
REQ-035 Same-cycle write addr 5 = all-ones with be = 0x0F and read addr 5 (prior value 0), Forward = 1 -> data 0x00000000FFFFFFFF; with Forward = 0 -> data 0.
REQ-036 Hold ack_rd_retry = 1 and issue 3 reads -> 2 accepted, req_rd_retry = 1 on the third; after release, data emerges in order and the third read is accepted.
REQ-037 Back-to-back reads of addrs 0..7 with ack_rd_retry = 0 -> 8 consecutive ack_rd_valid cycles with no bubbles.
REQ-038 Assert reset with 2 responses buffered -> ack_rd_valid = 0 immediately; after release, INIT repeats and a read of a previously written address returns 0.
